// File: rtl/vga_sync_decoder_if.sv
// Bundles the sync inputs and the decoded timing outputs of the VGA sync
// decoder. The video source side (stimulus or loopback) uses the master
// modport; the decoder itself uses the slave modport.
interface vga_sync_decoder_if #(
  parameter int COUNTER_SIZE = 11
);

  logic                    hsync_in;
  logic                    vsync_in;
  logic [COUNTER_SIZE-1:0] pixel_x;
  logic [COUNTER_SIZE-1:0] line_y;
  logic                    active_video;
  logic                    frame_start;
  logic                    locked;
  logic [COUNTER_SIZE-1:0] line_length;
  logic                    sync_error;

  modport master (
    output hsync_in,
    output vsync_in,
    input  pixel_x,
    input  line_y,
    input  active_video,
    input  frame_start,
    input  locked,
    input  line_length,
    input  sync_error
  );

  modport slave (
    input  hsync_in,
    input  vsync_in,
    output pixel_x,
    output line_y,
    output active_video,
    output frame_start,
    output locked,
    output line_length,
    output sync_error
  );

endinterface

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: synchronises external hsync/vsync, measures the line
// period, locks once the period is stable and regenerates pixel/line
// coordinates plus an active-video window for the locked stream.
module vga_sync_decoder #(
  parameter int COUNTER_SIZE    = 11,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int H_ACTIVE_START  = 0,
  parameter int H_ACTIVE        = 1072,
  parameter int V_ACTIVE_START  = 0,
  parameter int V_ACTIVE        = 768,
  parameter int LOCK_LINES      = 4
) (
  input  logic              control_clock,
  input  logic              reset,
  vga_sync_decoder_if.slave bus
);

  localparam int CW = COUNTER_SIZE;
  localparam int MW = $clog2(LOCK_LINES + 1);

  localparam logic [CW-1:0] ALL_ONES    = '1;
  localparam logic [MW-1:0] LOCK_TARGET = MW'(LOCK_LINES);

  // Active window bounds kept one bit wider than the counters so that
  // start+length never overflows.
  localparam logic [CW:0] H_LO  = (CW + 1)'(H_ACTIVE_START);
  localparam logic [CW:0] H_LEN = (CW + 1)'(H_ACTIVE);
  localparam logic [CW:0] V_LO  = (CW + 1)'(V_ACTIVE_START);
  localparam logic [CW:0] V_LEN = (CW + 1)'(V_ACTIVE);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // Raw input level that means "sync not asserted".
  localparam logic DEASSERTED_LEVEL = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // ------------------------------------------------------------------
  // Input path: bit 0 = hsync, bit 1 = vsync
  // ------------------------------------------------------------------
  logic [1:0] sync_raw;
  logic [1:0] sync_edge;

  assign sync_raw = {bus.vsync_in, bus.hsync_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_q;
      logic s2_q;
      logic s3_q;
      logic s2_asserted;
      logic s3_asserted;

      // Two-flop synchroniser plus one history flop for edge detection.
      always_ff @(posedge control_clock) begin
        if (reset) begin
          s1_q <= DEASSERTED_LEVEL;
          s2_q <= DEASSERTED_LEVEL;
          s3_q <= DEASSERTED_LEVEL;
        end else begin
          s1_q <= sync_raw[gi];
          s2_q <= s1_q;
          s3_q <= s2_q;
        end
      end

      assign s2_asserted   = (SYNC_ACTIVE_LOW != 0) ? ~s2_q : s2_q;
      assign s3_asserted   = (SYNC_ACTIVE_LOW != 0) ? ~s3_q : s3_q;
      assign sync_edge[gi] = s2_asserted & ~s3_asserted;
    end
  endgenerate

  logic h_edge;
  logic v_edge;

  assign h_edge = sync_edge[0];
  assign v_edge = sync_edge[1];

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [1:0]    state_q,        state_d;
  logic [MW-1:0] match_q,        match_d;
  logic [CW:0]   ref_q,          ref_d;
  logic          ref_valid_q,    ref_valid_d;
  logic [CW-1:0] pixel_x_q,      pixel_x_d;
  logic [CW-1:0] line_y_q,       line_y_d;
  logic [CW-1:0] line_length_q,  line_length_d;
  logic          locked_q,       locked_d;
  logic          frame_start_q,  frame_start_d;
  logic          sync_error_q,   sync_error_d;
  logic          active_video_q, active_video_d;

  // Period of the line ending at this h-edge; one bit wider so that an
  // all-ones pixel_x cannot wrap to zero.
  logic [CW:0] period;
  logic        hsync_timeout;

  assign period        = {1'b0, pixel_x_q} + {{CW{1'b0}}, 1'b1};
  assign hsync_timeout = (pixel_x_q == ALL_ONES) && (state_q != ST_SEARCH);

  // Coordinate counters: vsync wins over hsync for line_y, line_y saturates.
  always_comb begin
    if (h_edge) begin
      pixel_x_d = '0;
    end else begin
      pixel_x_d = pixel_x_q + 1'b1;
    end

    line_y_d = line_y_q;
    if (v_edge) begin
      line_y_d = '0;
    end else if (h_edge && (line_y_q != ALL_ONES)) begin
      line_y_d = line_y_q + 1'b1;
    end
  end

  // Lock state machine: search, measure a stable period, track while locked.
  always_comb begin
    state_d       = state_q;
    match_d       = match_q;
    ref_d         = ref_q;
    ref_valid_d   = ref_valid_q;
    line_length_d = line_length_q;
    locked_d      = locked_q;
    frame_start_d = 1'b0;
    sync_error_d  = 1'b0;

    if (hsync_timeout) begin
      // hsync has vanished long enough that the counter saturated.
      state_d      = ST_SEARCH;
      locked_d     = 1'b0;
      match_d      = '0;
      ref_valid_d  = 1'b0;
      sync_error_d = (state_q == ST_LOCKED);
    end else begin
      case (state_q)
        ST_SEARCH: begin
          locked_d = 1'b0;
          match_d  = '0;
          // This first edge only starts a line; what came before it is
          // not a real period, so no reference is taken yet.
          if (h_edge) begin
            state_d     = ST_MEASURE;
            ref_valid_d = 1'b0;
          end
        end

        ST_MEASURE: begin
          if (h_edge) begin
            if (ref_valid_q && (period == ref_q)) begin
              if (match_q < LOCK_TARGET) begin
                match_d = match_q + MW'(1);
              end
            end else begin
              match_d     = MW'(1);
              ref_d       = period;
              ref_valid_d = 1'b1;
            end
          end
          if (v_edge && (match_d >= LOCK_TARGET)) begin
            state_d       = ST_LOCKED;
            locked_d      = 1'b1;
            line_length_d = ref_d[CW-1:0];
            frame_start_d = 1'b1;
          end
        end

        ST_LOCKED: begin
          if (h_edge && (period != {1'b0, line_length_q})) begin
            state_d      = ST_SEARCH;
            locked_d     = 1'b0;
            match_d      = '0;
            ref_valid_d  = 1'b0;
            sync_error_d = 1'b1;
          end else if (v_edge) begin
            frame_start_d = 1'b1;
          end
        end

        default: begin
          state_d     = ST_SEARCH;
          locked_d    = 1'b0;
          match_d     = '0;
          ref_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Active window evaluated on the next-cycle coordinates so the registered
  // flag lines up with the registered pixel_x/line_y it describes.
  logic [CW:0] h_offset;
  logic [CW:0] v_offset;

  always_comb begin
    h_offset       = {1'b0, pixel_x_d} - H_LO;
    v_offset       = {1'b0, line_y_d} - V_LO;
    active_video_d = locked_d && (h_offset < H_LEN) && (v_offset < V_LEN);
  end

  // All decoder registers, cleared synchronously.
  always_ff @(posedge control_clock) begin
    if (reset) begin
      state_q        <= ST_SEARCH;
      match_q        <= '0;
      ref_q          <= '0;
      ref_valid_q    <= 1'b0;
      pixel_x_q      <= '0;
      line_y_q       <= '0;
      line_length_q  <= '0;
      locked_q       <= 1'b0;
      frame_start_q  <= 1'b0;
      sync_error_q   <= 1'b0;
      active_video_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      match_q        <= match_d;
      ref_q          <= ref_d;
      ref_valid_q    <= ref_valid_d;
      pixel_x_q      <= pixel_x_d;
      line_y_q       <= line_y_d;
      line_length_q  <= line_length_d;
      locked_q       <= locked_d;
      frame_start_q  <= frame_start_d;
      sync_error_q   <= sync_error_d;
      active_video_q <= active_video_d;
    end
  end

  assign bus.pixel_x      = pixel_x_q;
  assign bus.line_y       = line_y_q;
  assign bus.line_length  = line_length_q;
  assign bus.locked       = locked_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.sync_error   = sync_error_q;
  assign bus.active_video = active_video_q;

endmodule
